// File: rtl/tick_pkg.sv
// Shared defaults and mode encoding for the multi-channel tick generator.
package tick_pkg;

  localparam int unsigned CNT_W_DEF       = 18;
  localparam int unsigned DEFAULT_DIV_DEF = 200000;  // 500 Hz from 100 MHz

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } tick_mode_e;

  // Smallest select width able to address n channels (at least 1 bit).
  function automatic int unsigned sel_w_for(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int unsigned SEL_W_DEF = sel_w_for(8);

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, shadow/active divisor pair and output register.
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_data,
  input  logic             i_mode,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_active;
  logic             r_tick;

  logic [CNT_W-1:0] w_next_div;
  logic             w_halted;
  logic             w_wrap;
  logic             w_pulse;

  // A write landing on the wrap edge bypasses the shadow straight into active.
  always_comb begin
    w_next_div = i_wr ? i_data : r_shadow;
    w_halted   = (r_active == '0);
    w_wrap     = (r_cnt == (r_active - CNT_W'(1)));
    w_pulse    = (i_mode == MODE_PULSE);
  end

  // Counter, divisor reload and output register, in priority rst > sync > load > count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_shadow <= CNT_W'(DEFAULT_DIV);
      r_active <= CNT_W'(DEFAULT_DIV);
      r_tick   <= 1'b0;
    end else if (i_sync) begin
      r_cnt    <= '0;
      r_active <= r_shadow;
      r_tick   <= 1'b0;
    end else begin
      if (i_wr) r_shadow <= i_data;
      if (w_halted) begin
        // Halted channels pick up a new divisor immediately; counting starts next edge.
        r_cnt    <= '0;
        r_active <= w_next_div;
        if (w_pulse) r_tick <= 1'b0;
      end else if (!i_en) begin
        if (w_pulse) r_tick <= 1'b0;
      end else if (w_wrap) begin
        r_cnt    <= '0;
        r_active <= w_next_div;
        r_tick   <= w_pulse ? 1'b1 : ~r_tick;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_pulse) r_tick <= 1'b0;
      end
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick / clock-enable generator.
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int unsigned SEL_W       = SEL_W_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  input  logic [NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_wr;

  // Route the write strobe to the selected channel; out-of-range selects match nothing.
  always_comb begin
    w_wr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (div_wr && (32'(div_sel) == i)) w_wr[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_en   (en),
      .i_sync (sync),
      .i_wr   (w_wr[g]),
      .i_data (div_data),
      .i_mode (mode[g]),
      .o_tick (tick[g])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: directed scenarios plus random traffic against a reference model.
module tb_tick_gen_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DEF    = 8;
  localparam int unsigned SEL_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              sync;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] tick;

  always #5 clk = ~clk;

  tick_gen_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF),
    .SEL_W       (SEL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_data (div_data),
    .mode     (mode),
    .tick     (tick)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: enabled cycles elapsed in the current period, period length, pending divisor, output.
  int m_elapsed [NUM_CH];
  int m_period  [NUM_CH];
  int m_pending [NUM_CH];
  bit m_out     [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        m_elapsed[i] = 0;
        m_period[i]  = DEF;
        m_pending[i] = DEF;
        m_out[i]     = 1'b0;
      end else if (sync) begin
        m_elapsed[i] = 0;
        m_period[i]  = m_pending[i];
        m_out[i]     = 1'b0;
      end else begin
        if (div_wr && (int'(div_sel) == i)) m_pending[i] = int'(div_data);
        if (m_period[i] == 0) begin
          m_period[i]  = m_pending[i];
          m_elapsed[i] = 0;
          if (!mode[i]) m_out[i] = 1'b0;
        end else if (!en) begin
          if (!mode[i]) m_out[i] = 1'b0;
        end else begin
          m_elapsed[i] = m_elapsed[i] + 1;
          if (m_elapsed[i] == m_period[i]) begin
            m_elapsed[i] = 0;
            m_period[i]  = m_pending[i];
            m_out[i]     = mode[i] ? !m_out[i] : 1'b1;
          end else if (!mode[i]) begin
            m_out[i] = 1'b0;
          end
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later, strobes cleared.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("%s ch%0d", tag, i), {31'b0, tick[i]}, {31'b0, m_out[i]});
    rst    = 1'b0;
    sync   = 1'b0;
    div_wr = 1'b0;
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic wr(input int sel, input int data);
    div_wr   = 1'b1;
    div_sel  = SEL_W'(sel);
    div_data = CNT_W'(data);
    step("wr");
  endtask

  initial begin
    int r;
    rst = 1'b1; en = 1'b1; sync = 1'b0; div_wr = 1'b0;
    div_sel = '0; div_data = '0; mode = '0;

    step("reset");
    chk("reset_tick", 32'(tick), 32'd0);
    run("default_div", 26);

    // New divisor mid-period on ch1; current period finishes first.
    run("pre_wr", 3);
    wr(1, 3);
    run("div3", 20);

    // Square mode on ch2 with D=5.
    mode[2] = 1'b1;
    wr(2, 5);
    run("square", 30);

    // Enable freeze on ch0 with D=6, then halt and resume.
    wr(0, 6);
    run("d6", 14);
    en = 1'b0;
    run("en_low", 4);
    en = 1'b1;
    run("en_resume", 16);
    wr(0, 0);
    run("halt", 14);
    wr(0, 2);
    run("resume_d2", 10);

    // Phase alignment via sync.
    wr(0, 4);
    wr(1, 6);
    run("free", 7);
    sync = 1'b1;
    step("sync");
    chk("sync_square", {31'b0, tick[2]}, 32'd0);
    run("post_sync", 14);

    // Out-of-range select must not touch any channel.
    wr(7, 1);
    run("sel7", 20);

    // D=1 in pulse mode holds the output high while enabled.
    mode[3] = 1'b0;
    wr(3, 1);
    run("d1_load", 10);
    for (int k = 0; k < 4; k++) begin
      step("d1");
      chk("d1_high", {31'b0, tick[3]}, 32'd1);
    end

    // Write coinciding with the wrap edge: wait until the model says ch1 is at its last count.
    for (int k = 0; k < 12 && (m_elapsed[1] != m_period[1] - 1); k++) step("seek_wrap");
    wr(1, 5);
    run("bypass", 15);

    // Reset mid-period.
    run("mid", 3);
    rst = 1'b1;
    step("rst_mid");
    chk("rst_mid_tick", 32'(tick), 32'd0);
    run("after_rst", 12);

    // Random traffic.
    for (int k = 0; k < 2500; k++) begin
      en     = ($urandom_range(0, 9) != 0);
      sync   = ($urandom_range(0, 99) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      div_wr = ($urandom_range(0, 5) == 0);
      div_sel = SEL_W'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      div_data = (r == 0) ? '0 : (r == 1) ? CNT_W'(1) : CNT_W'($urandom_range(2, 12));
      if ($urandom_range(0, 39) == 0) mode = NUM_CH'($urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
